// File: rtl/set_assoc_lru_cache.sv
// rtl/set_assoc_lru_cache.sv - N-way set-associative write-through data cache with true LRU
//
// Purpose: one-word-line, write-through, no-write-allocate data cache between the
// memory stage and data memory. Every memory transaction stalls the pipeline.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   MemReadM/MemWriteM  load/store request (held stable while Stall=1)
//   ALUResultM          byte address; WriteDataM store data
//   Data, Hit, Stall    load data to ReadDataW, same-cycle load hit, pipeline freeze
//   Datamem_wire, MemValid_wire                    memory read data / completion
//   MemRead_wire, MemWrite_wire, MemAddress_wire, MemWriteData_wire  memory request
//   HitCount, MissCount load hit/miss performance counters (wrapping)
module set_assoc_lru_cache #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] Data,
  output logic        Hit,
  output logic        Stall,
  input  logic [31:0] Datamem_wire,
  input  logic        MemValid_wire,
  output logic        MemRead_wire,
  output logic        MemWrite_wire,
  output logic [31:0] MemAddress_wire,
  output logic [31:0] MemWriteData_wire,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
);

  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int AGE_BITS = $clog2(NUM_WAYS);
  localparam int TAG_BITS = 32 - SET_BITS - 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic                valid_q [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_q  [NUM_SETS][NUM_WAYS];
  logic [AGE_BITS-1:0] age_q   [NUM_SETS][NUM_WAYS];

  // Lookup uses the live address in IDLE and the latched address while waiting.
  logic [SET_BITS-1:0] lk_set;
  logic [TAG_BITS-1:0] lk_tag;
  logic                hit_any;
  logic [AGE_BITS-1:0] hit_way;
  logic [AGE_BITS-1:0] victim_way;
  logic                inv_found;

  logic                touch_en;
  logic [AGE_BITS-1:0] touch_way;
  logic                fill_en;
  logic                wupd_en;

  always_comb begin
    lk_set = (state_q == IDLE) ? ALUResultM[SET_BITS+1:2] : addr_q[SET_BITS+1:2];
    lk_tag = (state_q == IDLE) ? ALUResultM[31:SET_BITS+2] : addr_q[31:SET_BITS+2];
    hit_any    = 1'b0;
    hit_way    = '0;
    inv_found  = 1'b0;
    victim_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (valid_q[lk_set][i] && (tag_q[lk_set][i] == lk_tag) && !hit_any) begin
        hit_any = 1'b1;
        hit_way = AGE_BITS'(i);
      end
      if (!valid_q[lk_set][i] && !inv_found) begin
        inv_found  = 1'b1;
        victim_way = AGE_BITS'(i);
      end
    end
    // With no free way, the least recently used way carries the oldest age.
    if (!inv_found) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (age_q[lk_set][i] == AGE_BITS'(NUM_WAYS - 1)) victim_way = AGE_BITS'(i);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    hit_cnt_d         = hit_cnt_q;
    miss_cnt_d        = miss_cnt_q;
    Data              = rdata_q;
    Hit               = 1'b0;
    Stall             = 1'b0;
    MemRead_wire      = 1'b0;
    MemWrite_wire     = 1'b0;
    MemAddress_wire   = addr_q;
    MemWriteData_wire = wdata_q;
    touch_en          = 1'b0;
    touch_way         = hit_way;
    fill_en           = 1'b0;
    wupd_en           = 1'b0;
    case (state_q)
      IDLE: begin
        MemAddress_wire   = ALUResultM;
        MemWriteData_wire = WriteDataM;
        if (MemWriteM) begin
          Stall   = 1'b1;
          addr_d  = ALUResultM;
          wdata_d = WriteDataM;
          state_d = WR_WAIT;
        end else if (MemReadM) begin
          if (hit_any) begin
            Hit       = 1'b1;
            Data      = data_q[lk_set][hit_way];
            touch_en  = 1'b1;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            Stall      = 1'b1;
            addr_d     = ALUResultM;
            miss_cnt_d = miss_cnt_q + 32'd1;
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        MemRead_wire = 1'b1;
        Stall        = 1'b1;
        touch_way    = victim_way;
        if (MemValid_wire) begin
          fill_en  = 1'b1;
          touch_en = 1'b1;
          rdata_d  = Datamem_wire;
          state_d  = RESP;
        end
      end
      WR_WAIT: begin
        MemWrite_wire = 1'b1;
        Stall         = 1'b1;
        if (MemValid_wire) begin
          wupd_en  = hit_any;
          touch_en = hit_any;
          state_d  = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs go quiet the moment reset is raised, before any clock edge.
    if (rst) begin
      Hit           = 1'b0;
      Stall         = 1'b0;
      MemRead_wire  = 1'b0;
      MemWrite_wire = 1'b0;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Valid bits and ages are reset; ages start as way index so they form a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_BITS'(w);
        end
      end
    end else begin
      if (fill_en) valid_q[lk_set][touch_way] <= 1'b1;
      if (touch_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (AGE_BITS'(w) == touch_way) begin
            age_q[lk_set][w] <= '0;
          end else if (age_q[lk_set][w] < age_q[lk_set][touch_way]) begin
            age_q[lk_set][w] <= age_q[lk_set][w] + AGE_BITS'(1);
          end
        end
      end
    end
  end

  // Tag and data arrays are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[lk_set][touch_way]  <= lk_tag;
      data_q[lk_set][touch_way] <= Datamem_wire;
    end else if (wupd_en) begin
      data_q[lk_set][touch_way] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_set_assoc_lru_cache.sv
// tb/tb_set_assoc_lru_cache.sv - directed scoreboard bench for set_assoc_lru_cache
module tb_set_assoc_lru_cache;

  logic        clk;
  logic        rst;
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [31:0] addr_i [2];
  logic [31:0] wd_i   [2];
  logic [31:0] dmem_i [2];
  logic        mval_i [2];
  logic [31:0] data_o [2];
  logic        hit_o  [2];
  logic        stall_o[2];
  logic        mrd_o  [2];
  logic        mwr_o  [2];
  logic [31:0] maddr_o[2];
  logic [31:0] mwd_o  [2];
  logic [31:0] hitc_o [2];
  logic [31:0] missc_o[2];

  int checks   = 0;
  int failures = 0;
  int exp_hits  [2];
  int exp_misses[2];

  logic [31:0] mem [logic [31:0]];
  logic [31:0] sb [$];

  set_assoc_lru_cache dut0 (
    .clk(clk), .rst(rst),
    .MemReadM(rd_i[0]), .MemWriteM(wr_i[0]), .ALUResultM(addr_i[0]), .WriteDataM(wd_i[0]),
    .Data(data_o[0]), .Hit(hit_o[0]), .Stall(stall_o[0]),
    .Datamem_wire(dmem_i[0]), .MemValid_wire(mval_i[0]),
    .MemRead_wire(mrd_o[0]), .MemWrite_wire(mwr_o[0]),
    .MemAddress_wire(maddr_o[0]), .MemWriteData_wire(mwd_o[0]),
    .HitCount(hitc_o[0]), .MissCount(missc_o[0])
  );

  set_assoc_lru_cache #(.NUM_SETS(16), .NUM_WAYS(4)) dut1 (
    .clk(clk), .rst(rst),
    .MemReadM(rd_i[1]), .MemWriteM(wr_i[1]), .ALUResultM(addr_i[1]), .WriteDataM(wd_i[1]),
    .Data(data_o[1]), .Hit(hit_o[1]), .Stall(stall_o[1]),
    .Datamem_wire(dmem_i[1]), .MemValid_wire(mval_i[1]),
    .MemRead_wire(mrd_o[1]), .MemWrite_wire(mwr_o[1]),
    .MemAddress_wire(maddr_o[1]), .MemWriteData_wire(mwd_o[1]),
    .HitCount(hitc_o[1]), .MissCount(missc_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(int d);
    chk("hit_count", hitc_o[d], 32'(exp_hits[d]));
    chk("miss_count", missc_o[d], 32'(exp_misses[d]));
  endtask

  // Load: expected word pushed at issue, popped when Data is valid (hit cycle or RESP).
  task automatic load(int d, logic [31:0] a, bit exp_hit);
    logic [31:0] word;
    word = mem_rd(a);
    sb.push_back(word);
    rd_i[d] = 1'b1;
    addr_i[d] = a;
    @(negedge clk);
    chk("ld_hit", 32'(hit_o[d]), 32'(exp_hit));
    chk("ld_stall", 32'(stall_o[d]), 32'(!exp_hit));
    if (exp_hit) begin
      chk("hit_no_memrd", 32'(mrd_o[d]), 32'd0);
      chk("hit_data", data_o[d], sb.pop_front());
      @(posedge clk); #1;
      rd_i[d] = 1'b0;
      exp_hits[d]++;
    end else begin
      @(posedge clk); #1;
      exp_misses[d]++;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("rd_memrd", 32'(mrd_o[d]), 32'd1);
        chk("rd_memwr", 32'(mwr_o[d]), 32'd0);
        chk("rd_addr", maddr_o[d], a);
        if (k == 2) begin
          mval_i[d] = 1'b1;
          dmem_i[d] = word;
        end
        @(posedge clk); #1;
      end
      mval_i[d] = 1'b0;
      dmem_i[d] = 32'h0;
      @(negedge clk);
      chk("resp_stall", 32'(stall_o[d]), 32'd0);
      chk("resp_hit", 32'(hit_o[d]), 32'd0);
      chk("resp_data", data_o[d], sb.pop_front());
      @(posedge clk); #1;
      rd_i[d] = 1'b0;
    end
    chk_counts(d);
  endtask

  task automatic store(int d, logic [31:0] a, logic [31:0] v);
    wr_i[d] = 1'b1;
    addr_i[d] = a;
    wd_i[d] = v;
    @(negedge clk);
    chk("st_stall", 32'(stall_o[d]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("st_memwr", 32'(mwr_o[d]), 32'd1);
    chk("st_memrd", 32'(mrd_o[d]), 32'd0);
    chk("st_addr", maddr_o[d], a);
    chk("st_wdata", mwd_o[d], v);
    mval_i[d] = 1'b1;
    @(posedge clk); #1;
    mval_i[d] = 1'b0;
    mem[a] = v;
    @(negedge clk);
    chk("st_resp_stall", 32'(stall_o[d]), 32'd0);
    chk("st_resp_memwr", 32'(mwr_o[d]), 32'd0);
    @(posedge clk); #1;
    wr_i[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = '0; wd_i[d] = '0;
      dmem_i[d] = '0; mval_i[d] = 1'b0; exp_hits[d] = 0; exp_misses[d] = 0;
    end
    mem[32'h100] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall_o[0]), 32'd0);
    chk("rst_hit", 32'(hit_o[0]), 32'd0);
    chk("rst_data", data_o[0], 32'h0);
    chk("rst_memrd", 32'(mrd_o[0]), 32'd0);
    chk("rst_memwr", 32'(mwr_o[0]), 32'd0);
    rst = 1'b0;
    chk_counts(0);

    // 16 sets x 4 ways: five loads to set 0, the fifth evicts the oldest (0x000).
    load(1, 32'h000, 1'b0);
    load(1, 32'h040, 1'b0);
    load(1, 32'h080, 1'b0);
    load(1, 32'h0C0, 1'b0);
    load(1, 32'h100, 1'b0);
    load(1, 32'h040, 1'b1);
    load(1, 32'h000, 1'b0);

    // Basic miss then hit.
    load(0, 32'h100, 1'b0);
    load(0, 32'h100, 1'b1);

    // Store hit updates cached word; store miss does not allocate.
    store(0, 32'h100, 32'h12345678);
    load(0, 32'h100, 1'b1);
    store(0, 32'h200, 32'hCAFEF00D);
    load(0, 32'h200, 1'b0);

    // LRU ordering within set 0 of the 2-way cache.
    load(0, 32'h000, 1'b0);
    load(0, 32'h010, 1'b0);
    load(0, 32'h000, 1'b1);
    load(0, 32'h020, 1'b0);
    load(0, 32'h000, 1'b1);
    load(0, 32'h010, 1'b0);

    // Reset raised mid-read drops the transaction and clears state at once.
    rd_i[0] = 1'b1;
    addr_i[0] = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_memrd", 32'(mrd_o[0]), 32'd1);
    #2;
    rst = 1'b1;
    rd_i[0] = 1'b0;
    #1;
    chk("async_rst_memrd", 32'(mrd_o[0]), 32'd0);
    chk("async_rst_stall", 32'(stall_o[0]), 32'd0);
    chk("async_rst_data", data_o[0], 32'h0);
    exp_hits[0] = 0;
    exp_misses[0] = 0;
    chk_counts(0);
    @(posedge clk); #1;
    rst = 1'b0;
    load(0, 32'h100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/set_assoc_lru_cache.md
Name: set_assoc_lru_cache

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate data cache. One-word lines.
- Sits between the memory stage and data memory. Drives the ReadDataW path and stalls the pipeline on every memory transaction.
- Replacement uses true LRU per set. Memory access uses a valid handshake.
- Includes hit and miss performance counters.

Parameters:
- NUM_SETS, 4: number of sets. Power of 2, at least 2. SET_BITS = log2(NUM_SETS).
- NUM_WAYS, 2: ways per set. Power of 2, at least 2. AGE_BITS = log2(NUM_WAYS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- MemReadM  in  1  load request.
- MemWriteM  in  1  store request.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data.
- Data  out  32  load data, connects to ReadDataW.
- Hit  out  1  load hit in the current cycle.
- Stall  out  1  freeze the pipeline; the request inputs are held stable while Stall=1.
- Datamem_wire  in  32  read data from memory.
- MemValid_wire  in  1  memory transaction complete.
- MemRead_wire  out  1  memory read request.
- MemWrite_wire  out  1  memory write request.
- MemAddress_wire  out  32  memory address.
- MemWriteData_wire  out  32  memory write data.
- HitCount  out  32  count of load hits; wraps.
- MissCount  out  32  count of load misses; wraps.

Behaviour:
- Address split: Offset = [1:0] (ignored); Set = [SET_BITS+1:2]; Tag = [31:SET_BITS+2].
- Per-line state: valid bit, tag, 32-bit data word, AGE_BITS age value.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE; all valid bits = 0; age of way i = i in every set.
  - Data = 0; Hit, Stall, MemRead_wire, MemWrite_wire = 0.
  - Latched address, latched data and both counters = 0.
  - An in-flight fill is discarded.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE, no request: Stall = 0, Hit = 0, no memory activity.
- IDLE, load hit: decided combinationally.
  - Hit = 1, Data = matching way's data, Stall = 0.
  - On the clock edge: LRU touch of that way; HitCount+1.
- IDLE, load miss:
  - Stall = 1 combinationally; Hit = 0.
  - On the clock edge: latch address, MissCount+1, go to RD_WAIT.
- IDLE, store (MemWriteM = 1; store wins if MemReadM is also 1):
  - Stall = 1.
  - On the clock edge: latch address and WriteDataM, go to WR_WAIT.
- RD_WAIT:
  - MemRead_wire = 1; MemAddress_wire = latched address; Stall = 1.
  - On MemValid_wire: write Datamem_wire into the victim way (lowest-index invalid way, else the way with age NUM_WAYS-1). Set valid, write tag, LRU touch, latch the word, go to RESP.
- WR_WAIT:
  - MemWrite_wire = 1; MemAddress_wire and MemWriteData_wire = latched values; Stall = 1.
  - On MemValid_wire: if the tag hits, update that way's data and LRU touch; a store miss allocates nothing. Go to RESP.
- RESP:
  - Stall = 0, Hit = 0, Data = latched word (store: unchanged latch value).
  - The held request retires this cycle with no lookup and no re-issue. Next state IDLE.
- MemValid_wire is ignored in IDLE and RESP.
- MemRead_wire and MemWrite_wire are never both 1. Both are 0 outside their wait states.
- In IDLE, MemAddress_wire = ALUResultM and MemWriteData_wire = WriteDataM.
- LRU touch of way w with old age a: age[w] = 0; every way in the set whose age is < a increments. Ages stay a permutation of 0..NUM_WAYS-1 at all times.
- Memory latency is unbounded; the block waits indefinitely.
- Load-miss latency: 1 request cycle + memory cycles + 1 RESP cycle.

Test Plan:
- Default parameters, reset, load 0x100.
  - Expect Stall=1, then MemRead_wire=1 with MemAddress_wire=0x100.
  - MemValid_wire after 3 cycles with 0xDEADBEEF -> RESP Data=0xDEADBEEF, Stall=0.
  - Reload 0x100 -> Hit=1, Data=0xDEADBEEF in the same cycle, no memory request. HitCount=1, MissCount=1.
- LRU: load 0x000, then 0x010 (both set 0), then hit 0x000, then load 0x020.
  - 0x020 evicts the 0x010 line.
  - Load 0x000 -> Hit=1; load 0x010 -> miss.
- Store hit 0x12345678 to cached 0x100.
  - MemWrite_wire=1, MemAddress_wire=0x100, MemWriteData_wire=0x12345678.
  - After valid, load 0x100 -> Hit=1, Data=0x12345678.
- Store to uncached 0x200 -> memory write occurs; a following load 0x200 misses (no allocate).
- Assert rst during RD_WAIT -> MemRead_wire=0 and Stall=0 immediately, counters=0. Load 0x100 afterwards misses.
- NUM_SETS=16, NUM_WAYS=4: loads to 0x000, 0x040, 0x080, 0x0C0, then 0x100 (all set 0).
  - Fifth load evicts 0x000.
  - Reload 0x040 -> hit; reload 0x000 -> miss.
